// File: rtl/spectral_peak_picker_pkg.sv
// Shared types and width constants for the spectral peak picker.
package spectral_peak_pkg;
  localparam int DEF_NFFT       = 256;
  localparam int DEF_AMP_WIDTH  = 32;
  localparam int DEF_NUM_BANDS  = 8;
  localparam int DEF_TIME_WIDTH = 32;

  localparam int BIN_W    = $clog2(DEF_NFFT);
  localparam int BAND_W   = $clog2(DEF_NUM_BANDS);
  localparam int BAND_LEN = DEF_NFFT / DEF_NUM_BANDS;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [BAND_W-1:0]        band;
    logic [BIN_W-1:0]         bin;
    logic [DEF_AMP_WIDTH-1:0] amplitude;
  } peak_rec_t;
endpackage

// File: rtl/spectral_peak_picker_tracker.sv
// Running max/argmax for one band at a time; best_* include the bin being offered this cycle.
module band_max_tracker
  import spectral_peak_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [BIN_W-1:0]         bin,
  input  logic [DEF_AMP_WIDTH-1:0] amplitude,
  output logic [BIN_W-1:0]         best_bin,
  output logic [DEF_AMP_WIDTH-1:0] best_amplitude
);
  logic [BIN_W-1:0]         max_bin;
  logic [DEF_AMP_WIDTH-1:0] max_amp;
  logic                     take;

  // strict compare keeps the lowest index on ties
  assign take           = en && (load || amplitude > max_amp);
  assign best_bin       = take ? bin : max_bin;
  assign best_amplitude = take ? amplitude : max_amp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_bin <= '0;
      max_amp <= '0;
    end else begin
      max_bin <= best_bin;
      max_amp <= best_amplitude;
    end
  end
endmodule

// File: rtl/spectral_peak_picker.sv
// Per-band peak picker over a serialised magnitude frame.
// Optional PEAK_THRESHOLD_EN skips band records below peak_threshold.
module spectral_peak_picker
  import spectral_peak_pkg::*;
#(
  parameter int NFFT       = DEF_NFFT,
  parameter int AMP_WIDTH  = DEF_AMP_WIDTH,
  parameter int NUM_BANDS  = DEF_NUM_BANDS,
  parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bin_valid,
  output logic                         bin_ready,
  input  logic                         bin_first,
  input  logic                         bin_last,
  input  logic [AMP_WIDTH-1:0]         bin_amplitude,
`ifdef PEAK_THRESHOLD_EN
  input  logic [AMP_WIDTH-1:0]         peak_threshold,
`endif
  output logic                         peak_valid,
  input  logic                         peak_ready,
  output logic [$clog2(NUM_BANDS)-1:0] peak_band,
  output logic [$clog2(NFFT)-1:0]      peak_bin,
  output logic [AMP_WIDTH-1:0]         peak_amplitude,
  output logic [TIME_WIDTH-1:0]        peak_time,
  output logic                         frame_done,
  output logic                         frame_error
);
  // record struct is sized from the package, so the parameters must agree with it
  if (NFFT != DEF_NFFT || AMP_WIDTH != DEF_AMP_WIDTH || NUM_BANDS != DEF_NUM_BANDS)
  begin : g_bad_cfg
    $error("spectral_peak_picker parameters differ from spectral_peak_pkg defaults");
  end

  state_t                     state;
  logic [BIN_W-1:0]           idx;
  logic [BAND_W-1:0]          ptr;
  logic [TIME_WIDTH-1:0]      frame_cnt;
  logic [NUM_BANDS-1:0]       keep_q;
  peak_rec_t [NUM_BANDS-1:0]  band_q;
  peak_rec_t [NUM_BANDS-1:0]  band_view;
  logic [NUM_BANDS-1:0]       keep_view;

  logic                       in_frame, restart_err, last_err, at_end;
  logic                       first_of_band, last_of_band, wr_en, enter_drain, xfer;
  logic [BIN_W-1:0]           cur_idx;
  logic [BAND_W-1:0]          cur_band;
  logic [BIN_W-1:0]           trk_bin;
  logic [AMP_WIDTH-1:0]       trk_amp;
  peak_rec_t                  new_rec;
  logic [NUM_BANDS-1:0]       search_mask;
  int                         search_start;
  logic                       nxt_found;
  logic [BAND_W-1:0]          nxt_band;

  assign in_frame      = bin_valid && bin_ready && (state == SCAN || (state == IDLE && bin_first));
  assign cur_idx       = bin_first ? '0 : idx;
  assign at_end        = cur_idx == BIN_W'(NFFT - 1);
  assign last_err      = bin_last != at_end;
  assign restart_err   = state == SCAN && bin_first;
  assign first_of_band = (cur_idx & BIN_W'(BAND_LEN - 1)) == '0;
  assign last_of_band  = (cur_idx & BIN_W'(BAND_LEN - 1)) == BIN_W'(BAND_LEN - 1);
  assign cur_band      = cur_idx[BIN_W-1 -: BAND_W];
  assign wr_en         = in_frame && last_of_band && !last_err;
  assign enter_drain   = in_frame && at_end && !last_err;
  assign xfer          = state == DRAIN && peak_valid && peak_ready;

  band_max_tracker u_tracker (
    .clk            (clk),
    .rst            (reset),
    .en             (in_frame),
    .load           (first_of_band),
    .bin            (cur_idx),
    .amplitude      (bin_amplitude),
    .best_bin       (trk_bin),
    .best_amplitude (trk_amp)
  );

  assign new_rec = '{band: cur_band, bin: trk_bin, amplitude: trk_amp};

  // the last band is written on the same edge DRAIN is entered, so bypass it
  always_comb begin
    for (int b = 0; b < NUM_BANDS; b++) begin
      band_view[b] = (wr_en && cur_band == BAND_W'(b)) ? new_rec : band_q[b];
`ifdef PEAK_THRESHOLD_EN
      keep_view[b] = band_view[b].amplitude >= peak_threshold;
`else
      keep_view[b] = 1'b1;
`endif
    end
  end

  assign search_mask  = enter_drain ? keep_view : keep_q;
  assign search_start = enter_drain ? 0 : int'(ptr) + 1;

  always_comb begin
    nxt_found = 1'b0;
    nxt_band  = '0;
    for (int i = NUM_BANDS - 1; i >= 0; i--) begin
      if (i >= search_start && search_mask[i]) begin
        nxt_found = 1'b1;
        nxt_band  = BAND_W'(i);
      end
    end
  end

  assign peak_time = frame_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      ptr            <= '0;
      frame_cnt      <= '0;
      keep_q         <= '0;
      band_q         <= '0;
      bin_ready      <= 1'b1;
      peak_valid     <= 1'b0;
      peak_band      <= '0;
      peak_bin       <= '0;
      peak_amplitude <= '0;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      if (wr_en) band_q[cur_band] <= new_rec;
      case (state)
        IDLE, SCAN: begin
          if (in_frame) begin
            frame_error <= restart_err || last_err;
            if (last_err) begin
              state <= IDLE;
            end else if (at_end) begin
              keep_q <= keep_view;
              if (nxt_found) begin
                state          <= DRAIN;
                bin_ready      <= 1'b0;
                peak_valid     <= 1'b1;
                ptr            <= nxt_band;
                peak_band      <= band_view[nxt_band].band;
                peak_bin       <= band_view[nxt_band].bin;
                peak_amplitude <= band_view[nxt_band].amplitude;
              end else begin
                state      <= IDLE;
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 1'b1;
              end
            end else begin
              state <= SCAN;
              idx   <= cur_idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (nxt_found) begin
              ptr            <= nxt_band;
              peak_band      <= band_q[nxt_band].band;
              peak_bin       <= band_q[nxt_band].bin;
              peak_amplitude <= band_q[nxt_band].amplitude;
            end else begin
              state      <= IDLE;
              peak_valid <= 1'b0;
              bin_ready  <= 1'b1;
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spectral_peak_picker.sv
// Directed bench for spectral_peak_picker; threshold case runs when PEAK_THRESHOLD_EN is defined.
module tb_spectral_peak_picker;
  logic        clk, reset;
  logic        bin_valid, bin_ready, bin_first, bin_last;
  logic [31:0] bin_amplitude;
  logic        peak_valid, peak_ready;
  logic [2:0]  peak_band;
  logic [7:0]  peak_bin;
  logic [31:0] peak_amplitude, peak_time;
  logic        frame_done, frame_error;
`ifdef PEAK_THRESHOLD_EN
  logic [31:0] peak_threshold;
`endif

  int vectors = 0, miscompares = 0, err_seen = 0;
  int amps [256];
  int eb [8], ebin [8], eamp [8];
  int etime;

  spectral_peak_picker dut (
    .clk(clk), .reset(reset),
    .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_first(bin_first),
    .bin_last(bin_last), .bin_amplitude(bin_amplitude),
`ifdef PEAK_THRESHOLD_EN
    .peak_threshold(peak_threshold),
`endif
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_band(peak_band),
    .peak_bin(peak_bin), .peak_amplitude(peak_amplitude), .peak_time(peak_time),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_error) err_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bins(input int n, input int first_at, input int last_at, input bit stop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bin_valid = 1'b1;
      bin_first = (i == first_at);
      bin_last  = (i == last_at);
      bin_amplitude = amps[i];
    end
    if (stop) begin
      @(negedge clk);
      bin_valid = 1'b0; bin_first = 1'b0; bin_last = 1'b0;
    end
  endtask

  // peak_ready must be high; starts at a negedge where the first record may already be shown
  task automatic drain_recs(input int first, input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      if (peak_valid) begin
        chk("peak_band", peak_band, eb[first+got]);
        chk("peak_bin", peak_bin, ebin[first+got]);
        chk("peak_amp", peak_amplitude, eamp[first+got]);
        chk("peak_time", peak_time, etime);
        chk("bin_ready_in_drain", bin_ready, 0);
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("drain_count", got, n);
  endtask

  task automatic done_check();
    chk("frame_done_pulse", frame_done, 1);
    chk("valid_low_after_drain", peak_valid, 0);
    chk("bin_ready_back", bin_ready, 1);
    @(negedge clk);
    chk("frame_done_one_cycle", frame_done, 0);
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 256; i++) amps[i] = i;
    for (int b = 0; b < 8; b++) begin eb[b] = b; ebin[b] = b*32 + 31; eamp[b] = b*32 + 31; end
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_bin_ready"}, bin_ready, 1);
    chk({tag, "_peak_valid"}, peak_valid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_error"}, frame_error, 0);
    chk({tag, "_peak_band"}, peak_band, 0);
    chk({tag, "_peak_bin"}, peak_bin, 0);
    chk({tag, "_peak_amp"}, peak_amplitude, 0);
    chk({tag, "_peak_time"}, peak_time, 0);
  endtask

  initial begin
    int e0;
    reset = 1'b1; bin_valid = 1'b0; bin_first = 1'b0; bin_last = 1'b0;
    bin_amplitude = '0; peak_ready = 1'b1;
`ifdef PEAK_THRESHOLD_EN
    peak_threshold = '0;
`endif
    repeat (2) @(negedge clk);
    reset_outputs_check("reset");
    reset = 1'b0;
    @(negedge clk);
    reset_outputs_check("post_reset");

    // bins without bin_first while idle are dropped
    for (int i = 0; i < 256; i++) amps[i] = 9999;
    send_bins(5, -1, -1, 1);
    repeat (2) @(negedge clk);
    chk("idle_drop_valid", peak_valid, 0);
    chk("idle_drop_err", err_seen, 0);

    // ramp
    set_ramp(); etime = 0;
    send_bins(256, 0, 255, 1);
    chk("ramp_valid_rise", peak_valid, 1);
    drain_recs(0, 8);
    done_check();

    // ties keep the lowest index
    for (int i = 0; i < 256; i++) amps[i] = 5;
    for (int b = 0; b < 8; b++) begin eb[b] = b; ebin[b] = b*32; eamp[b] = 5; end
    etime = 1;
    send_bins(256, 0, 255, 1);
    drain_recs(0, 8);
    done_check();

    // backpressure with impulse in band 2
    for (int i = 0; i < 256; i++) amps[i] = 0;
    amps[70] = 1000;
    for (int b = 0; b < 8; b++) begin eb[b] = b; ebin[b] = b*32; eamp[b] = 0; end
    ebin[2] = 70; eamp[2] = 1000; etime = 2;
    send_bins(256, 0, 255, 1);
    drain_recs(0, 2);
    chk("bp_band", peak_band, 2);
    chk("bp_bin", peak_bin, 70);
    chk("bp_amp", peak_amplitude, 1000);
    peak_ready = 1'b0;
    @(negedge clk);
    chk("bp_hold_valid", peak_valid, 1);
    chk("bp_hold_band", peak_band, 2);
    chk("bp_hold_bin", peak_bin, 70);
    chk("bp_hold_amp", peak_amplitude, 1000);
    chk("bp_hold_ready", bin_ready, 0);
    peak_ready = 1'b1;
    drain_recs(2, 6);
    done_check();

    // reset in the middle of DRAIN
    set_ramp(); etime = 3;
    send_bins(256, 0, 255, 1);
    drain_recs(0, 3);
    reset = 1'b1;
    #1;
    reset_outputs_check("mid_drain_reset");
    @(negedge clk);
    reset = 1'b0;

    // bin_last too early
    e0 = err_seen;
    send_bins(101, 0, 100, 1);
    chk("early_last_err", frame_error, 1);
    chk("early_last_valid", peak_valid, 0);
    @(negedge clk);
    chk("early_last_err_1cyc", frame_error, 0);
    chk("early_last_err_count", err_seen - e0, 1);

    // index NFFT-1 without bin_last
    send_bins(256, 0, -1, 1);
    chk("missing_last_err", frame_error, 1);
    chk("missing_last_ready", bin_ready, 1);
    repeat (3) @(negedge clk);
    chk("missing_last_valid", peak_valid, 0);

    // next good frame is still stamped 0
    set_ramp(); etime = 0;
    send_bins(256, 0, 255, 1);
    drain_recs(0, 8);
    done_check();

    // bin_first mid-scan restarts the frame
    e0 = err_seen;
    for (int i = 0; i < 256; i++) amps[i] = 32'hFFFF_FFFF;
    send_bins(50, 0, -1, 0);
    set_ramp(); etime = 1;
    send_bins(256, 0, 255, 1);
    chk("restart_err_count", err_seen - e0, 1);
    drain_recs(0, 8);
    done_check();

`ifdef PEAK_THRESHOLD_EN
    for (int i = 0; i < 256; i++) amps[i] = 0;
    amps[40] = 600; amps[200] = 600;
    peak_threshold = 500;
    eb[0] = 1; ebin[0] = 40;  eamp[0] = 600;
    eb[1] = 6; ebin[1] = 200; eamp[1] = 600;
    etime = 2;
    send_bins(256, 0, 255, 1);
    drain_recs(0, 2);
    done_check();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
